rv32_store_buffer: RTL
======================

Name: rv32_store_buffer

Overview:
- Holds committed CPU stores in a small in-order FIFO and drains them to the data-memory write port one per handshake. This is the writer end of the delayed-write path.
- Supplies load forwarding from pending entries, so a younger load to a buffered address returns the buffered data instead of stale memory data.
- Sits between the execute/memory stage (store issue, load lookup) and the data-memory write port.

Parameters:
- DEPTH, 4, number of store entries; must be a power of two, 2..16.
- AW, 32, address width in bits; the word address is addr[AW-1:2].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high; clears all state
- st_valid  input  1  store request from the pipeline
- st_ready  output  1  buffer can accept a store this cycle
- st_addr  input  AW  store byte address; bits [1:0] are ignored and data is word-aligned
- st_data  input  32  store data, already lane-aligned
- st_be  input  4  byte enables; 4'b0000 is legal and is stored and drained like any other store
- ld_addr  input  AW  load address for the forwarding lookup
- ld_hit  output  1  forward ld_data in place of memory data
- ld_data  output  32  forwarded word
- ld_stall  output  1  youngest matching entry is partial; the load must wait
- mem_valid  output  1  head entry presented to memory
- mem_ready  input  1  memory accepts the head entry
- mem_addr  output  AW  head word address, with [1:0] forced to 0
- mem_wdata  output  32  head data
- mem_be  output  4  head byte enables
- empty  output  1  no entries pending; used by fence and ecall drain logic
- count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage is a circular array of {valid, addr, data, be} per entry, with a head and a tail pointer of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH.
- Reset (rst=1 at a clock edge) clears:
  - head, tail and count to 0;
  - every valid bit.
- While rst=1 and on the cycle after reset:
  - st_ready=0 while rst=1;
  - after reset, st_ready=1, mem_valid=0, ld_hit=0, ld_stall=0, empty=1, count=0;
  - ld_data is don't-care when ld_hit=0; the implementation drives 0.
- Reset asserted mid-operation discards all pending stores without draining them. Any mem handshake in that same cycle is ignored.
- Enqueue:
  - st_ready = !rst && (count != DEPTH);
  - on st_valid && st_ready, the entry is written at tail and tail increments;
  - a full buffer does not accept a store in the same cycle it drains; st_ready depends only on registered count.
- Drain:
  - mem_valid = (count != 0); mem_addr, mem_wdata and mem_be come from the head entry and are registered values with no combinational path from st_*;
  - on mem_valid && mem_ready, the head valid bit is cleared and head increments;
  - mem_* must stay stable while mem_valid=1 and mem_ready=0.
- Count rules:
  - push only: +1; pop only: -1; push and pop together: unchanged;
  - on an empty buffer, push and pop cannot coincide;
  - a store accepted at edge N is first presented on mem_* in cycle N+1, a minimum latency of 1 cycle.
- Forwarding (combinational on ld_addr and registered entries):
  - an entry matches when valid=1 and addr[AW-1:2] == ld_addr[AW-1:2];
  - the youngest matching entry, searched from the entry nearest tail backwards, decides the result;
  - youngest be==4'hF: ld_hit=1, ld_data=its data, ld_stall=0;
  - youngest be partial (including 0): ld_hit=0, ld_stall=1;
  - no match: ld_hit=0, ld_stall=0.
- Forwarding edge cases:
  - a store being enqueued in the current cycle is not visible to the lookup; the pipeline guarantees one cycle of separation;
  - the head entry remains forwardable in the cycle it is popped.
- empty = (count == 0).
- X on st_* is tolerated when st_valid=0. X on ld_addr must not propagate into state.

Test Plan:
- Reset then idle: after rst held 2 cycles, expect count=0, empty=1, st_ready=1, mem_valid=0, ld_hit=0, ld_stall=0.
- Single store: push addr 0x100, data 0xDEADBEEF, be F with mem_ready=0. Next cycle expect mem_valid=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, and the same values held 3 cycles. Then mem_ready=1 for one cycle → empty=1.
- Fill and wrap: with mem_ready=0, push 4 stores (0x0, 0x4, 0x8, 0xC) and expect st_ready=0 at count=4. Pop one, push 0x10. Drain all and expect memory order 0x4, 0x8, 0xC, 0x10 after the first.
- Forwarding youngest wins: push 0x200/0x11111111/F, then 0x200/0x22222222/F. ld_addr=0x202 → ld_hit=1, ld_data=0x22222222. ld_addr=0x204 → ld_hit=0, ld_stall=0.
- Partial stall: push 0x300/0xAB/be 0001. ld_addr=0x300 → ld_stall=1, ld_hit=0. After it drains → ld_stall=0.
- Simultaneous push/pop and reset mid-stream:
  - with count=2 and mem_ready=1, push one store → count stays 2;
  - assert rst with 3 entries pending → next cycle count=0, mem_valid=0, and no further memory writes.

Source files
------------

// File: rtl/rv32_store_buffer.sv
// In-order store buffer: queues committed stores, drains them one per memory
// handshake, and forwards full-word pending data to younger loads.
module rv32_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  input  logic [3:0]             st_be,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [31:0]            ld_data,
  output logic                   ld_stall,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] valid_reg;
  logic [AW-3:0]    addr_reg [DEPTH];
  logic [31:0]      data_reg [DEPTH];
  logic [3:0]       be_reg   [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] match;
  logic             fwd_found;
  logic [PW-1:0]    fwd_idx;
  logic [PW-1:0]    scan_idx;
  logic             fwd_full;
  logic             unused_lsbs;

  // Byte offsets are irrelevant: everything is tracked per word.
  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Readiness depends only on registered occupancy, so a full buffer never
  // accepts a store in the cycle it drains.
  assign st_ready  = !rst && (count_reg != FULL);
  assign push      = st_valid && st_ready;
  assign mem_valid = (count_reg != '0);
  assign pop       = mem_valid && mem_ready && !rst;

  assign mem_addr  = {addr_reg[head_reg], 2'b00};
  assign mem_wdata = data_reg[head_reg];
  assign mem_be    = be_reg[head_reg];
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push) begin
        tail_reg            <= tail_reg + 1'b1;
        valid_reg[tail_reg] <= 1'b1;
      end
      if (pop) begin
        head_reg            <= head_reg + 1'b1;
        valid_reg[head_reg] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload needs no reset; the valid bits and count gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_reg[tail_reg] <= st_addr[AW-1:2];
      data_reg[tail_reg] <= st_data;
      be_reg[tail_reg]   <= st_be;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (addr_reg[gi] == ld_addr[AW-1:2]);
  end

  // Scan oldest to youngest; the last match seen is the youngest.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = head_reg;
    scan_idx  = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_reg + PW'(k);
      if (match[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign fwd_full = (be_reg[fwd_idx] == 4'hF);
  assign ld_hit   = fwd_found && fwd_full;
  assign ld_stall = fwd_found && !fwd_full;
  assign ld_data  = ld_hit ? data_reg[fwd_idx] : 32'h0;

endmodule
